mrv1_issue_sched: RTL

- Per-cycle issue scheduler for the multithreaded mtcore execute stage.
- Each hardware thread presents at most one decoded instruction. The block tracks per-thread register write hazards in a scoreboard and arbitrates the single execute datapath (operand mux + ALU) round-robin among hazard-free threads.
- It gates access to one shared multi-cycle unit (mul/div) and grants exactly one thread per cycle toward the execute source mux.

---
 rtl/mrv1_issue_sched_if.sv | 41 ++++
 rtl/mrv1_issue_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/mrv1_issue_sched_if.sv
// Issue-side bundle between the decode/thread front end and the issue scheduler.
// master = thread/execute/writeback environment, slave = the scheduler itself.
interface mrv1_issue_sched_if #(
  parameter int NUM_THREADS_P = 4,
  parameter int REG_ADDR_W_P  = 5,
  parameter int TID_W_P       = $clog2(NUM_THREADS_P)
);
  logic [NUM_THREADS_P-1:0]              thr_valid_i;
  logic [NUM_THREADS_P*REG_ADDR_W_P-1:0] thr_rs0_addr_i;
  logic [NUM_THREADS_P*REG_ADDR_W_P-1:0] thr_rs1_addr_i;
  logic [NUM_THREADS_P-1:0]              thr_rs0_used_i;
  logic [NUM_THREADS_P-1:0]              thr_rs1_used_i;
  logic [NUM_THREADS_P*REG_ADDR_W_P-1:0] thr_rd_addr_i;
  logic [NUM_THREADS_P-1:0]              thr_rd_we_i;
  logic [NUM_THREADS_P-1:0]              thr_mc_i;
  logic [NUM_THREADS_P-1:0]              thr_ready_o;
  logic                                  exe_ready_i;
  logic                                  issue_valid_o;
  logic [TID_W_P-1:0]                    issue_tid_o;
  logic                                  wb_valid_i;
  logic [TID_W_P-1:0]                    wb_tid_i;
  logic [REG_ADDR_W_P-1:0]               wb_rd_addr_i;
  logic                                  flush_i;
  logic [TID_W_P-1:0]                    flush_tid_i;
  logic                                  mc_busy_o;
  logic [31:0]                           stall_cnt_o;

  modport master (
    output thr_valid_i, thr_rs0_addr_i, thr_rs1_addr_i, thr_rs0_used_i, thr_rs1_used_i,
    output thr_rd_addr_i, thr_rd_we_i, thr_mc_i, exe_ready_i,
    output wb_valid_i, wb_tid_i, wb_rd_addr_i, flush_i, flush_tid_i,
    input  thr_ready_o, issue_valid_o, issue_tid_o, mc_busy_o, stall_cnt_o
  );

  modport slave (
    input  thr_valid_i, thr_rs0_addr_i, thr_rs1_addr_i, thr_rs0_used_i, thr_rs1_used_i,
    input  thr_rd_addr_i, thr_rd_we_i, thr_mc_i, exe_ready_i,
    input  wb_valid_i, wb_tid_i, wb_rd_addr_i, flush_i, flush_tid_i,
    output thr_ready_o, issue_valid_o, issue_tid_o, mc_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/mrv1_issue_sched.sv
// Per-cycle issue scheduler: per-thread register scoreboard, round-robin grant of the
// single execute datapath and occupancy gating of the shared multi-cycle unit.
module mrv1_issue_sched #(
  parameter int NUM_THREADS_P = 4,
  parameter int REG_ADDR_W_P  = 5,
  parameter int MC_LAT_P      = 4,
  parameter int TID_W_P       = $clog2(NUM_THREADS_P)
) (
  input logic               clk_i,
  input logic               rst_ni,
  mrv1_issue_sched_if.slave bus
);
  localparam int NREG_LP = 1 << REG_ADDR_W_P;
  localparam int MC_W_LP = (MC_LAT_P > 1) ? $clog2(MC_LAT_P) : 1;

  logic [NUM_THREADS_P-1:0] elig;
  logic [NUM_THREADS_P-1:0] grant;
  logic [TID_W_P-1:0]       grant_tid;
  logic [TID_W_P-1:0]       arb_idx;
  logic                     found;
  logic                     issue;
  logic [TID_W_P-1:0]       rr_q, rr_d;
  logic [MC_W_LP-1:0]       mc_cnt_q, mc_cnt_d;
  logic [31:0]              stall_q, stall_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS_P; gi++) begin : g_thr
      logic [NREG_LP-1:0]      pend_q, pend_d;
      logic [REG_ADDR_W_P-1:0] rs0, rs1, rd;
      logic                    flushed;

      assign rs0     = bus.thr_rs0_addr_i[gi*REG_ADDR_W_P +: REG_ADDR_W_P];
      assign rs1     = bus.thr_rs1_addr_i[gi*REG_ADDR_W_P +: REG_ADDR_W_P];
      assign rd      = bus.thr_rd_addr_i[gi*REG_ADDR_W_P +: REG_ADDR_W_P];
      assign flushed = bus.flush_i && (bus.flush_tid_i == TID_W_P'(gi));

      // Hazard check looks only at registered state: a writeback frees the register next cycle.
      assign elig[gi] = rst_ni && bus.exe_ready_i && bus.thr_valid_i[gi] && !flushed
                        && !(bus.thr_rs0_used_i[gi] && pend_q[rs0])
                        && !(bus.thr_rs1_used_i[gi] && pend_q[rs1])
                        && !(bus.thr_rd_we_i[gi] && (rd != '0) && pend_q[rd])
                        && !(bus.thr_mc_i[gi] && (mc_cnt_q != '0));

      // Priority: flush over set, set over writeback clear.
      always_comb begin
        pend_d = pend_q;
        if (bus.wb_valid_i && (bus.wb_tid_i == TID_W_P'(gi))) begin
          pend_d[bus.wb_rd_addr_i] = 1'b0;
        end
        if (grant[gi] && bus.thr_rd_we_i[gi] && (rd != '0)) begin
          pend_d[rd] = 1'b1;
        end
        if (flushed) begin
          pend_d = '0;
        end
        pend_d[0] = 1'b0;
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          pend_q <= '0;
        end else begin
          pend_q <= pend_d;
        end
      end
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_tid = '0;
    arb_idx   = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      arb_idx = rr_q + TID_W_P'(i + 1);
      if (!found && elig[arb_idx]) begin
        found            = 1'b1;
        grant[arb_idx]   = 1'b1;
        grant_tid        = arb_idx;
      end
    end
  end

  assign issue = |grant;

  always_comb begin
    rr_d     = issue ? grant_tid : rr_q;
    mc_cnt_d = mc_cnt_q;
    if (issue && bus.thr_mc_i[grant_tid]) begin
      mc_cnt_d = MC_W_LP'(MC_LAT_P - 1);
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_W_LP'(1);
    end
    stall_d = stall_q;
    if ((|bus.thr_valid_i) && !issue && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= TID_W_P'(NUM_THREADS_P - 1);
      mc_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      mc_cnt_q <= mc_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.thr_ready_o   = grant;
  assign bus.issue_valid_o = issue;
  assign bus.issue_tid_o   = grant_tid;
  assign bus.mc_busy_o     = rst_ni && (mc_cnt_q != '0);
  assign bus.stall_cnt_o   = stall_q;
endmodule
